// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cond_unit
//  Purpose  : Architectural NZCV flag register plus condition evaluator with
//             a predicated-block window. A block marker latches one condition
//             that the next N issued instructions share. The block ends early
//             on a flush, and a nested marker raises an error pulse.
//  Ports    : clk, rst_n       - clock (rising edge), async active-low reset
//             valid            - instruction issued this cycle
//             cond             - condition field of the issued instruction
//             set_flags        - issued instruction writes flags
//             alu_flag         - new {N,Z,C,V} from the ALU
//             blk_start        - issued instruction is a block marker
//             blk_len          - block length carried by the marker
//             flush            - pipeline flush (highest priority)
//             exec             - issued instruction executes (combinational)
//             flag             - registered flags [3]=N [2]=Z [1]=C [0]=V
//             blk_active       - predicated block in progress
//             blk_remain       - instructions left in the block
//             blk_err          - one-cycle pulse after a nested marker
//  Revision : 1.0  initial release
// ============================================================================
module cond_unit #(
  parameter int COND_W  = 4,
  parameter int BLK_MAX = 4,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [COND_W-1:0] cond,
  input  logic              set_flags,
  input  logic [3:0]        alu_flag,
  input  logic              blk_start,
  input  logic [CNT_W-1:0]  blk_len,
  input  logic              flush,
  output logic              exec,
  output logic [3:0]        flag,
  output logic              blk_active,
  output logic [CNT_W-1:0]  blk_remain,
  output logic              blk_err
);

  localparam logic [CNT_W-1:0] c_blk_max = CNT_W'(BLK_MAX);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_zero    = '0;

  logic [3:0]        r_flag;
  logic              r_blk_active;
  logic [CNT_W-1:0]  r_blk_remain;
  logic [COND_W-1:0] r_blk_cond;
  logic              r_blk_err;

  logic [COND_W-1:0] w_eff_cond;
  logic [3:0]        w_code;
  logic              w_true;
  logic              w_issue;
  logic [CNT_W-1:0]  w_len_clip;

  // Inside a block the instruction's own condition field is ignored.
  assign w_eff_cond = r_blk_active ? r_blk_cond : cond;

  // The legacy 2-bit field maps onto codes 0-3 of the full table.
  generate
    if (COND_W == 4) begin : g_cond_full
      assign w_code = w_eff_cond;
    end else begin : g_cond_legacy
      assign w_code = {2'b00, w_eff_cond};
    end
  endgenerate

  always_comb begin
    w_true = 1'b0;
    case (w_code)
      4'd0:    w_true = 1'b1;                                   // AL
      4'd1:    w_true = r_flag[2];                              // EQ
      4'd2:    w_true = ~r_flag[3];                             // PL
      4'd3:    w_true = r_flag[3];                              // MI
      4'd4:    w_true = ~r_flag[2];                             // NE
      4'd5:    w_true = r_flag[1];                              // CS
      4'd6:    w_true = ~r_flag[1];                             // CC
      4'd7:    w_true = r_flag[0];                              // VS
      4'd8:    w_true = ~r_flag[0];                             // VC
      4'd9:    w_true = r_flag[1] & ~r_flag[2];                 // HI
      4'd10:   w_true = ~r_flag[1] | r_flag[2];                 // LS
      4'd11:   w_true = (r_flag[3] == r_flag[0]);               // GE
      4'd12:   w_true = (r_flag[3] != r_flag[0]);               // LT
      4'd13:   w_true = ~r_flag[2] & (r_flag[3] == r_flag[0]);  // GT
      4'd14:   w_true = r_flag[2] | (r_flag[3] != r_flag[0]);   // LE
      default: w_true = 1'b0;                                   // NV
    endcase
  end

  assign w_issue    = valid & ~flush;
  assign exec       = w_issue & ~blk_start & w_true;
  assign w_len_clip = (blk_len > c_blk_max) ? c_blk_max : blk_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag       <= 4'b0000;
      r_blk_active <= 1'b0;
      r_blk_remain <= c_zero;
      r_blk_cond   <= '0;
      r_blk_err    <= 1'b0;
    end else begin
      // exec already excludes flushed and squashed instructions.
      if (exec && set_flags) begin
        r_flag <= alu_flag;
      end
      r_blk_err <= w_issue & blk_start & r_blk_active;
      if (flush) begin
        r_blk_active <= 1'b0;
        r_blk_remain <= c_zero;
      end else if (valid) begin
        if (r_blk_active) begin
          // Every issued instruction consumes a slot, nested markers too.
          r_blk_remain <= r_blk_remain - c_one;
          if (r_blk_remain == c_one) begin
            r_blk_active <= 1'b0;
          end
        end else if (blk_start && (blk_len != c_zero)) begin
          r_blk_cond   <= cond;
          r_blk_remain <= w_len_clip;
          r_blk_active <= 1'b1;
        end
      end
    end
  end

  assign flag       = r_flag;
  assign blk_active = r_blk_active;
  assign blk_remain = r_blk_remain;
  assign blk_err    = r_blk_err;

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cond_unit
//  Purpose  : Directed self-checking bench for cond_unit (4-bit instance plus
//             a legacy 2-bit instance sharing the same stimulus).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] cond = 4'd0;
  logic       set_flags = 1'b0;
  logic [3:0] alu_flag = 4'd0;
  logic       blk_start = 1'b0;
  logic [2:0] blk_len = 3'd0;
  logic       flush = 1'b0;

  logic       exec, blk_active, blk_err;
  logic [3:0] flag;
  logic [2:0] blk_remain;
  logic       exec2, blk_active2, blk_err2;
  logic [3:0] flag2;
  logic [2:0] blk_remain2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cond_unit #(.COND_W(4), .BLK_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .cond(cond), .set_flags(set_flags),
    .alu_flag(alu_flag), .blk_start(blk_start), .blk_len(blk_len), .flush(flush),
    .exec(exec), .flag(flag), .blk_active(blk_active), .blk_remain(blk_remain),
    .blk_err(blk_err)
  );

  cond_unit #(.COND_W(2), .BLK_MAX(4), .CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .cond(cond[1:0]), .set_flags(set_flags),
    .alu_flag(alu_flag), .blk_start(blk_start), .blk_len(blk_len), .flush(flush),
    .exec(exec2), .flag(flag2), .blk_active(blk_active2), .blk_remain(blk_remain2),
    .blk_err(blk_err2)
  );

  // Stimulus only: applies one cycle's inputs and waits 1 time unit.
  task automatic drive(input logic v, input logic [3:0] c, input logic sf,
                       input logic [3:0] af, input logic bs, input logic [2:0] bl,
                       input logic fl);
    valid = v; cond = c; set_flags = sf; alu_flag = af;
    blk_start = bs; blk_len = bl; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_flags(input logic [3:0] f);
    drive(1, 4'd0, 1, f, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 4'd0, 1, 4'b1111, 0, 0, 0);
    tick();
    n_cmp++; if (flag !== 4'b0000) begin n_err++; $display("FAIL reset_flag got=%b exp=0000", flag); end
    n_cmp++; if (blk_active !== 1'b0) begin n_err++; $display("FAIL reset_active got=%b exp=0", blk_active); end
    n_cmp++; if (blk_remain !== 3'd0) begin n_err++; $display("FAIL reset_remain got=%0d exp=0", blk_remain); end
    n_cmp++; if (blk_err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", blk_err); end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_flag_update();
    drive(1, 4'd1, 0, 0, 0, 0, 0);
    n_cmp++; if (exec !== 1'b0) begin n_err++; $display("FAIL eq_z0 got=%b exp=0", exec); end
    tick();
    drive(1, 4'd0, 1, 4'b0100, 0, 0, 0);
    n_cmp++; if (exec !== 1'b1) begin n_err++; $display("FAIL al_set got=%b exp=1", exec); end
    tick();
    n_cmp++; if (flag !== 4'b0100) begin n_err++; $display("FAIL flag_write got=%b exp=0100", flag); end
    drive(1, 4'd1, 0, 0, 0, 0, 0);
    n_cmp++; if (exec !== 1'b1) begin n_err++; $display("FAIL eq_z1 got=%b exp=1", exec); end
    tick();
    // squashed instruction must not write flags
    drive(1, 4'd15, 1, 4'b1111, 0, 0, 0);
    tick();
    n_cmp++; if (flag !== 4'b0100) begin n_err++; $display("FAIL nv_no_write got=%b exp=0100", flag); end
  endtask

  task automatic test_conds();
    logic [3:0] codes [8];
    logic       exps  [8];
    codes = '{4'd11, 4'd12, 4'd2, 4'd3, 4'd15, 4'd13, 4'd14, 4'd0};
    exps  = '{1'b0,  1'b1,  1'b0, 1'b1, 1'b0,  1'b0,  1'b1,  1'b1};
    load_flags(4'b1000);
    for (int i = 0; i < 8; i++) begin
      drive(1, codes[i], 0, 0, 0, 0, 0);
      n_cmp++;
      if (exec !== exps[i]) begin
        n_err++; $display("FAIL cond_%0d got=%b exp=%b", codes[i], exec, exps[i]);
      end
      tick();
    end
    // C=1,Z=0: HI true, LS false, CS true, CC false
    load_flags(4'b0010);
    codes = '{4'd9, 4'd10, 4'd5, 4'd6, 4'd7, 4'd8, 4'd4, 4'd1};
    exps  = '{1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(1, codes[i], 0, 0, 0, 0, 0);
      n_cmp++;
      if (exec !== exps[i]) begin
        n_err++; $display("FAIL cond_c_%0d got=%b exp=%b", codes[i], exec, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_legacy();
    do_reset();
    load_flags(4'b1000);
    n_cmp++; if (flag2 !== 4'b1000) begin n_err++; $display("FAIL leg_flag got=%b exp=1000", flag2); end
    drive(1, 4'd2, 0, 0, 0, 0, 0);
    n_cmp++; if (exec2 !== 1'b0) begin n_err++; $display("FAIL leg_pl got=%b exp=0", exec2); end
    drive(1, 4'd3, 0, 0, 0, 0, 0);
    n_cmp++; if (exec2 !== 1'b1) begin n_err++; $display("FAIL leg_mi got=%b exp=1", exec2); end
    drive(1, 4'd1, 0, 0, 0, 0, 0);
    n_cmp++; if (exec2 !== 1'b0) begin n_err++; $display("FAIL leg_eq got=%b exp=0", exec2); end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_block();
    do_reset();
    drive(1, 4'd4, 0, 0, 1, 3'd3, 0);
    n_cmp++; if (exec !== 1'b0) begin n_err++; $display("FAIL marker_exec got=%b exp=0", exec); end
    tick();
    n_cmp++; if (blk_remain !== 3'd3) begin n_err++; $display("FAIL blk_rem3 got=%0d exp=3", blk_remain); end
    // idle cycle inside the block keeps the count
    drive(0, 4'd15, 0, 0, 0, 0, 0);
    tick();
    n_cmp++; if (blk_remain !== 3'd3) begin n_err++; $display("FAIL blk_idle got=%0d exp=3", blk_remain); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd15, 0, 0, 0, 0, 0);
      n_cmp++; if (exec !== 1'b1) begin n_err++; $display("FAIL blk_exec_%0d got=%b exp=1", i, exec); end
      tick();
      n_cmp++;
      if (blk_remain !== 3'(2 - i)) begin
        n_err++; $display("FAIL blk_count_%0d got=%0d exp=%0d", i, blk_remain, 2 - i);
      end
    end
    n_cmp++; if (blk_active !== 1'b0) begin n_err++; $display("FAIL blk_end got=%b exp=0", blk_active); end
    drive(1, 4'd15, 0, 0, 0, 0, 0);
    n_cmp++; if (exec !== 1'b0) begin n_err++; $display("FAIL post_blk_nv got=%b exp=0", exec); end
    // zero-length marker opens nothing
    drive(1, 4'd0, 0, 0, 1, 3'd0, 0);
    tick();
    n_cmp++; if (blk_active !== 1'b0) begin n_err++; $display("FAIL len0 got=%b exp=0", blk_active); end
    drive(1, 4'd0, 0, 0, 1, 3'd7, 0);
    tick();
    n_cmp++; if (blk_remain !== 3'd4) begin n_err++; $display("FAIL clip got=%0d exp=4", blk_remain); end
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'd15, 0, 0, 0, 0, 0);
      tick();
    end
    n_cmp++; if (blk_active !== 1'b0) begin n_err++; $display("FAIL clip_end got=%b exp=0", blk_active); end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_block_flag_write();
    do_reset();
    load_flags(4'b0100);
    drive(1, 4'd1, 0, 0, 1, 3'd3, 0);
    tick();
    drive(1, 4'd0, 1, 4'b0000, 0, 0, 0);
    n_cmp++; if (exec !== 1'b1) begin n_err++; $display("FAIL bfw_first got=%b exp=1", exec); end
    tick();
    n_cmp++; if (flag !== 4'b0000) begin n_err++; $display("FAIL bfw_flag got=%b exp=0000", flag); end
    for (int i = 0; i < 2; i++) begin
      drive(1, 4'd0, 0, 0, 0, 0, 0);
      n_cmp++; if (exec !== 1'b0) begin n_err++; $display("FAIL bfw_later_%0d got=%b exp=0", i, exec); end
      tick();
    end
    n_cmp++; if (blk_active !== 1'b0) begin n_err++; $display("FAIL bfw_end got=%b exp=0", blk_active); end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_nested();
    do_reset();
    drive(1, 4'd4, 0, 0, 1, 3'd3, 0);
    tick();
    drive(1, 4'd1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 4'd1, 0, 0, 1, 3'd4, 0);
    n_cmp++; if (exec !== 1'b0) begin n_err++; $display("FAIL nest_exec got=%b exp=0", exec); end
    n_cmp++; if (blk_err !== 1'b0) begin n_err++; $display("FAIL nest_err_pre got=%b exp=0", blk_err); end
    tick();
    n_cmp++; if (blk_remain !== 3'd1) begin n_err++; $display("FAIL nest_rem got=%0d exp=1", blk_remain); end
    // latched NE with Z=0 still holds, own EQ field ignored
    drive(1, 4'd1, 0, 0, 0, 0, 0);
    n_cmp++; if (blk_err !== 1'b1) begin n_err++; $display("FAIL nest_err got=%b exp=1", blk_err); end
    n_cmp++; if (exec !== 1'b1) begin n_err++; $display("FAIL nest_cond got=%b exp=1", exec); end
    tick();
    n_cmp++; if (blk_err !== 1'b0) begin n_err++; $display("FAIL nest_err_clr got=%b exp=0", blk_err); end
    n_cmp++; if (blk_active !== 1'b0) begin n_err++; $display("FAIL nest_end got=%b exp=0", blk_active); end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 4'd4, 0, 0, 1, 3'd3, 0);
    tick();
    drive(1, 4'd0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 4'd0, 1, 4'b1111, 0, 0, 1);
    n_cmp++; if (exec !== 1'b0) begin n_err++; $display("FAIL flush_exec got=%b exp=0", exec); end
    tick();
    n_cmp++; if (blk_active !== 1'b0) begin n_err++; $display("FAIL flush_active got=%b exp=0", blk_active); end
    n_cmp++; if (blk_remain !== 3'd0) begin n_err++; $display("FAIL flush_rem got=%0d exp=0", blk_remain); end
    n_cmp++; if (flag !== 4'b0000) begin n_err++; $display("FAIL flush_flag got=%b exp=0000", flag); end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    do_reset();
    load_flags(4'b1010);
    drive(1, 4'd0, 0, 0, 1, 3'd3, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (flag !== 4'b0000) begin n_err++; $display("FAIL arst_flag got=%b exp=0000", flag); end
    n_cmp++; if (blk_active !== 1'b0) begin n_err++; $display("FAIL arst_active got=%b exp=0", blk_active); end
    n_cmp++; if (blk_remain !== 3'd0) begin n_err++; $display("FAIL arst_rem got=%0d exp=0", blk_remain); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_flag_update();
    test_conds();
    test_legacy();
    test_block();
    test_block_flag_write();
    test_nested();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
